// File: rtl/snn_noc_pkg.sv
// Shared types for the neuromorphic NoC: default source-address width,
// the source-address type and the spike sender FSM states.
package snn_noc_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 12;

  typedef logic [ADDR_WIDTH_DEFAULT-1:0] src_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } sender_state_e;

endpackage

// File: rtl/spike_address_sender_if.sv
// Address-event stream: one source address per valid/ready transfer.
interface spike_address_sender_if
  import snn_noc_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) ();

  logic [ADDR_WIDTH-1:0] source_address;
  logic                  addr_valid;
  logic                  addr_ready;

  modport master (output source_address, output addr_valid, input addr_ready);
  modport slave  (input source_address, input addr_valid, output addr_ready);

endinterface

// File: rtl/lowest_set_bit_encoder.sv
// Combinational priority encoder: index of the lowest set bit plus an
// any-set flag.
module lowest_set_bit_encoder #(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic [NUM_NEURONS-1:0] vec_i,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_address_sender.sv
// Captures a fire vector and serialises it as BASE_ADDRESS + index addresses,
// lowest index first. Optional per-capture transfer counter: SPIKE_COUNT_EN.
module spike_address_sender
  import snn_noc_pkg::*;
#(
  parameter int NUM_NEURONS  = 8,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
  parameter int BASE_ADDRESS = 13,
  localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int CNT_W       = $clog2(NUM_NEURONS + 1)
) (
  input  logic                      CLK_Mac,
  input  logic                      reset,
  input  logic [NUM_NEURONS-1:0]    fire_vector,
  input  logic                      fire_valid,
  spike_address_sender_if.master    addr_if,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
`ifdef SPIKE_COUNT_EN
  ,
  output logic [CNT_W-1:0]          spike_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] BASE_Q = ADDR_WIDTH'(BASE_ADDRESS);

  sender_state_e          state_q, state_d;
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_any;
`ifdef SPIKE_COUNT_EN
  logic [CNT_W-1:0]       count_q, count_d;
`endif

  // Encode the next-cycle pending set so the registered address is ready
  // in the same cycle the capture or transfer takes effect.
  lowest_set_bit_encoder #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W)
  ) u_enc (
    .vec_i (pending_d),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    overflow_d = overflow_q;
`ifdef SPIKE_COUNT_EN
    count_d    = count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (fire_valid) begin
          pending_d = fire_vector;
          state_d   = (|fire_vector) ? SEND : DONE;
`ifdef SPIKE_COUNT_EN
          count_d   = '0;
`endif
        end
      end
      SEND: begin
        if (fire_valid) overflow_d = 1'b1;
        if (valid_q && addr_if.addr_ready) begin
          // x & (x-1) clears exactly the lowest set bit.
          pending_d = pending_q & (pending_q - NUM_NEURONS'(1));
`ifdef SPIKE_COUNT_EN
          count_d   = count_q + CNT_W'(1);
`endif
          if (pending_d == '0) state_d = DONE;
        end
      end
      DONE: begin
        if (fire_valid) overflow_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    addr_d  = enc_any ? (BASE_Q + ADDR_WIDTH'(enc_idx)) : addr_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge CLK_Mac) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      addr_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef SPIKE_COUNT_EN
      count_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
`ifdef SPIKE_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  assign addr_if.source_address = addr_q;
  assign addr_if.addr_valid     = valid_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign overflow               = overflow_q;
`ifdef SPIKE_COUNT_EN
  assign spike_count            = count_q;
`endif

endmodule
